reg_bank_arbiter: RTL

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters.
// Grants hold for up to MAX_BURST beats; completions return in transfer order after RD_LATENCY cycles.
module reg_bank_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]         req_wrdata,
  input  logic [NUM_REQ*4-1:0]          req_we,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [31:0]                   rsp_rddata,
  output logic                          BRAM_clk,
  output logic                          BRAM_rst,
  output logic [ADDR_WIDTH-1:0]         BRAM_addr,
  output logic [31:0]                   BRAM_wrdata,
  output logic [3:0]                    BRAM_we,
  output logic                          BRAM_en,
  input  logic [31:0]                   BRAM_rddata
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                         state;
  logic [IDX_W-1:0]               g;
  logic [IDX_W-1:0]               last;
  logic [BEAT_W-1:0]              beat;
  logic [IDX_W-1:0]               sel;
  logic                           sel_hit;
  int unsigned                    cand;
  logic                           xfer;
  logic                           last_beat;
  logic [RD_LATENCY-1:0]          pipe_v;
  logic [RD_LATENCY-1:0][IDX_W-1:0] pipe_o;

  // First valid requester after the previous winner, wrapping around.
  always_comb begin
    sel     = '0;
    sel_hit = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last) + i) % NUM_REQ;
      if (!sel_hit && req_valid[IDX_W'(cand)]) begin
        sel     = IDX_W'(cand);
        sel_hit = 1'b1;
      end
    end
  end

  assign req_ready   = (aresetn && state == GRANT) ? (NUM_REQ'(1) << g) : '0;
  assign xfer        = req_valid[g] & req_ready[g];
  assign last_beat   = (beat == BEAT_W'(MAX_BURST - 1));

  assign BRAM_clk    = aclk;
  assign BRAM_rst    = ~aresetn;
  assign BRAM_en     = xfer;
  assign BRAM_addr   = req_addr[32'(g)*ADDR_WIDTH +: ADDR_WIDTH];
  assign BRAM_wrdata = xfer ? req_wrdata[32'(g)*32 +: 32] : 32'h0;
  assign BRAM_we     = xfer ? req_we[32'(g)*4 +: 4] : 4'h0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      g     <= '0;
      last  <= LAST_RST;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_hit) begin
            g     <= sel;
            last  <= sel;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req_valid[g] || (xfer && last_beat)) begin
            state <= IDLE;
            beat  <= '0;
          end else if (xfer) begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion pipeline: one {valid, owner} entry per transfer, matched to BRAM read latency.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pipe_v <= '0;
      pipe_o <= '0;
    end else begin
      pipe_v[0] <= xfer;
      pipe_o[0] <= g;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_o[i] <= pipe_o[i-1];
      end
    end
  end

  assign rsp_valid  = (aresetn && pipe_v[RD_LATENCY-1]) ? (NUM_REQ'(1) << pipe_o[RD_LATENCY-1]) : '0;
  assign rsp_rddata = BRAM_rddata;

endmodule
